// File: rtl/rv_initiator_bfm_core_pkg.sv
// Shared types and defaults for the valid/ready initiator BFM core.
package rv_initiator_bfm_core_pkg;

  localparam int RV_DEF_WIDTH = 32;
  localparam int RV_DEF_DEPTH = 16;

  // Outcome of a host-side enqueue attempt.
  typedef enum logic [1:0] {
    RV_OK      = 2'd0,
    RV_DROPPED = 2'd1,
    RV_RESET   = 2'd2
  } rv_status_e;

  // Occupancy counters need one bit more than the address so that the
  // full count (DEPTH) can be represented.
  function automatic int rv_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rv_initiator_bfm_core_if.sv
// Valid/ready stream bundle driven by the initiator BFM.
interface rv_initiator_bfm_core_if
  import rv_initiator_bfm_core_pkg::*;
#(
  parameter int WIDTH = RV_DEF_WIDTH
);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             i_ready;

  // Initiator drives payload and valid, target answers with ready.
  modport master (output i_data, output i_valid, input i_ready);
  modport slave  (input i_data, input i_valid, output i_ready);

endinterface

// File: rtl/rv_initiator_bfm_core_fifo.sv
// Send queue for the initiator BFM: plain synchronous FIFO with a
// combinational head so the output stage can load it on the pop edge.
module rv_initiator_bfm_core_fifo
  import rv_initiator_bfm_core_pkg::*;
#(
  parameter int WIDTH = RV_DEF_WIDTH,
  parameter int DEPTH = RV_DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr;
  logic [AW:0]                 rd_ptr;

  // Pointers carry a wrap bit, so their difference is the occupancy.
  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; push while full is legal only alongside a pop, which
  // the caller guarantees.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rv_initiator_bfm_core.sv
// Initiator side of a valid/ready stream. A host pushes words through a
// simple push port; they are queued and presented on the bus one at a time,
// each held stable until the target accepts it.
module rv_initiator_bfm_core
  import rv_initiator_bfm_core_pkg::*;
#(
  parameter int WIDTH = RV_DEF_WIDTH,
  parameter int DEPTH = RV_DEF_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  rv_initiator_bfm_core_if.master bus,
  // host push port
  input  logic                    push_valid,
  input  logic [WIDTH-1:0]        push_data,
  output logic                    push_ready,
  output rv_status_e              push_status,
  // observability
  output logic [31:0]             tx_count,
  output logic [31:0]             enq_count,
  output logic [31:0]             drop_count,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  logic             xfer;
  logic             load_out;
  logic             push_fire;
  logic             bypass;

  // The output stage may take a new word when it is idle or its current
  // word leaves at this edge; ready is ignored while valid is low.
  assign xfer     = valid_q && bus.i_ready;
  assign load_out = !valid_q || bus.i_ready;

  // A full queue still takes a word when the head leaves on the same edge.
  assign push_ready = !reset && (!fifo_full || load_out);
  assign push_fire  = push_valid && push_ready;

  // With nothing queued ahead, a new word goes straight to the bus so it is
  // driven from the edge that accepts it.
  assign bypass    = push_fire && fifo_empty && load_out;
  assign fifo_push = push_fire && !bypass;
  assign fifo_pop  = !fifo_empty && load_out;

  // Host-facing status for the current push attempt.
  always_comb begin
    push_status = RV_OK;
    if (reset)            push_status = RV_RESET;
    else if (!push_ready) push_status = RV_DROPPED;
  end

  rv_initiator_bfm_core_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (level)
  );

  // Output register stage: queue head first, then a bypassed push; drop
  // valid once the last word has gone. Data keeps its last value when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (fifo_pop) begin
      valid_q <= 1'b1;
      data_q  <= fifo_head;
    end else if (bypass) begin
      valid_q <= 1'b1;
      data_q  <= push_data;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  // Transfer, accept and reject counters; all wrap modulo 2^32. A word in
  // flight on the reset edge is discarded and never counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_count   <= '0;
      enq_count  <= '0;
      drop_count <= '0;
    end else begin
      if (xfer)                     tx_count   <= tx_count + 32'd1;
      if (push_fire)                enq_count  <= enq_count + 32'd1;
      if (push_valid && !push_ready) drop_count <= drop_count + 32'd1;
    end
  end

  assign bus.i_valid = valid_q;
  assign bus.i_data  = data_q;
  assign idle        = fifo_empty && !valid_q;

endmodule

// File: tb/tb_rv_initiator_bfm_core.sv
// Bench for the valid/ready initiator BFM. Host tasks (send, send_nb,
// wait_idle, get_tx_count) wrap the push port; a monitor pops a scoreboard
// of expected words on every bus transfer.
module tb_rv_initiator_bfm_core;
  import rv_initiator_bfm_core_pkg::*;

  localparam int W = 32;
  localparam int D = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rv_initiator_bfm_core_if #(.WIDTH(W)) bus();

  logic                 rdy = 1'b0;
  logic                 push_valid = 1'b0;
  logic [W-1:0]         push_data = '0;
  logic                 push_ready;
  rv_status_e           push_status;
  logic [31:0]          tx_count;
  logic [31:0]          enq_count;
  logic [31:0]          drop_count;
  logic [$clog2(D):0]   level;
  logic                 idle;

  assign bus.i_ready = rdy;

  rv_initiator_bfm_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .push_status (push_status),
    .tx_count    (tx_count),
    .enq_count   (enq_count),
    .drop_count  (drop_count),
    .level       (level),
    .idle        (idle)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];   // words the bus must still carry, in order
  int  enq_total = 0;        // words accepted since the last reset
  int  epoch = 0;            // bumps on every bench-driven reset
  int  mode = 0;             // responder: 0 low, 1 high, 2 pulse, 3 random
  logic saw_valid = 1'b0;
  int  vcnt = 0;             // cycles with valid high
  int  xcnt = 0;             // transfers seen
  logic hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=completion", name);
  endtask

  // Responder: decides ready just after each edge.
  always @(posedge clock) begin
    #1;
    case (mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = rdy ? 1'b0 : saw_valid;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clock) saw_valid = bus.i_valid;

  // Monitor: a transfer is valid&&ready seen before the next edge.
  always @(negedge clock) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(bus.i_valid), 64'd1);
        chk("hold_data", 64'(bus.i_data), 64'(hold_data));
      end
      if (bus.i_valid) vcnt++;
      if (bus.i_valid && rdy) begin
        xcnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL xfer_unexpected actual=%0h required=none", bus.i_data);
        end else begin
          chk("xfer_data", 64'(bus.i_data), 64'(exp_q.pop_front()));
        end
      end
      hold_prev = bus.i_valid && !rdy;
      hold_data = bus.i_data;
    end
  end

  // Host API --------------------------------------------------------------
  // All tasks start and end just after a rising edge.
  task automatic send_nb(input logic [W-1:0] d, output logic ok);
    push_valid = 1'b1;
    push_data  = d;
    @(negedge clock);
    ok = push_ready;
    @(posedge clock);
    #1;
    push_valid = 1'b0;
    if (ok) begin
      exp_q.push_back(d);
      enq_total++;
    end
  endtask

  task automatic send(input logic [W-1:0] d, output rv_status_e st);
    logic ok;
    int   ticket;
    int   ep;
    ep = epoch;
    ok = 1'b0;
    st = RV_DROPPED;
    for (int i = 0; i < 200 && !ok && epoch == ep; i++) send_nb(d, ok);
    if (epoch != ep) begin
      $display("send: error, reset while waiting for queue space");
      st = RV_RESET;
      return;
    end
    if (!ok) begin
      fail_now("send_enqueue");
      return;
    end
    ticket = enq_total - 1;
    for (int i = 0; i < 500; i++) begin
      if (epoch != ep) begin
        $display("send: error, reset while word in flight");
        st = RV_RESET;
        return;
      end
      if (int'(tx_count) > ticket) begin
        st = RV_OK;
        return;
      end
      @(posedge clock);
      #1;
    end
    fail_now("send_complete");
  endtask

  task automatic get_tx_count(output int n);
    n = int'(tx_count);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (idle) return;
      @(posedge clock);
      #1;
    end
    fail_now(name);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_mode(input int m);
    mode = m;
    cycles(2);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ok;
    rv_status_e st;
    int         n;
    int         accepted;
    bit         done5;
    rv_status_e st5;
    logic [W-1:0] base;

    cycles(3);
    reset = 1'b0;

    // reset state
    chk("rst_valid", 64'(bus.i_valid), 64'd0);
    chk("rst_data", 64'(bus.i_data), 64'd0);
    chk("rst_tx", 64'(tx_count), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);

    // single blocking send through the pulsing responder
    set_mode(2);
    vcnt = 0;
    send(32'h1, st);
    chk("t1_status", 64'(st), 64'(RV_OK));
    wait_idle("t1_idle");
    get_tx_count(n);
    chk("t1_tx", 64'(n), 64'd1);
    chk("t1_vcycles", 64'(vcnt), 64'd2);

    // four non-blocking words, one transfer every second cycle
    vcnt = 0;
    xcnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_nb(W'(32'hA0 + i), ok);
      chk("t2_ok", 64'(ok), 64'd1);
    end
    wait_idle("t2_idle");
    chk("t2_tx", 64'(tx_count), 64'd5);
    chk("t2_xfers", 64'(xcnt), 64'd4);
    chk("t2_vcycles", 64'(vcnt), 64'd8);

    // ready held high: back-to-back transfers
    set_mode(1);
    vcnt = 0;
    xcnt = 0;
    for (int i = 0; i < 8; i++) begin
      send_nb(W'($urandom), ok);
      chk("t3_ok", 64'(ok), 64'd1);
    end
    wait_idle("t3_idle");
    chk("t3_xfers", 64'(xcnt), 64'd8);
    chk("t3_vcycles", 64'(vcnt), 64'd8);
    chk("t3_tx", 64'(tx_count), 64'd13);

    // ready held low: DEPTH queued plus one on the bus, then rejection
    set_mode(0);
    base = 32'hC000_0000;
    for (int i = 0; i < D + 2; i++) begin
      send_nb(base + W'(i), ok);
      chk("t4_ok", 64'(ok), (i < D + 1) ? 64'd1 : 64'd0);
    end
    chk("t4_data", 64'(bus.i_data), 64'(base));
    chk("t4_valid", 64'(bus.i_valid), 64'd1);
    chk("t4_level", 64'(level), 64'(D));
    chk("t4_drops", 64'(drop_count), 64'd1);
    // full queue still accepts when the head leaves on the same edge
    mode = 1;
    cycles(1);
    send_nb(32'hC0DE_0001, ok);
    chk("t4_full_swap_ok", 64'(ok), 64'd1);
    wait_idle("t4_idle");
    chk("t4_tx", 64'(tx_count), 64'(enq_total));
    chk("t4_enq", 64'(enq_count), 64'(enq_total));

    // reset mid-stream with a blocked send outstanding
    set_mode(0);
    for (int i = 0; i < 3; i++) send_nb(W'(32'hE0 + i), ok);
    done5 = 0;
    st5 = RV_OK;
    fork
      begin
        send(32'hDEAD_BEEF, st5);
        done5 = 1;
      end
    join_none
    cycles(3);
    chk("t5_valid_before", 64'(bus.i_valid), 64'd1);
    reset = 1'b1;
    push_valid = 1'b1;
    push_data = 32'h5555_5555;
    @(negedge clock);
    chk("t5_push_in_reset", 64'(push_ready), 64'd0);
    chk("t5_status_in_reset", 64'(push_status), 64'(RV_RESET));
    @(posedge clock);
    #1;
    reset = 1'b0;
    push_valid = 1'b0;
    exp_q.delete();
    enq_total = 0;
    epoch++;
    chk("t5_valid", 64'(bus.i_valid), 64'd0);
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_tx", 64'(tx_count), 64'd0);
    chk("t5_drops", 64'(drop_count), 64'd0);
    for (int i = 0; i < 5 && !done5; i++) cycles(1);
    if (!done5) fail_now("t5_send_return");
    else chk("t5_send_status", 64'(st5), 64'(RV_RESET));
    cycles(2);
    chk("t5_idle", 64'(idle), 64'd1);

    // random ready, 100 random words, random gaps
    set_mode(3);
    xcnt = 0;
    accepted = 0;
    for (int it = 0; it < 3000 && accepted < 100; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        send_nb(W'($urandom), ok);
        if (ok) accepted++;
      end else begin
        cycles(1);
      end
    end
    chk("t6_accepted", 64'(accepted), 64'd100);
    wait_idle("t6_idle");
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_xfers", 64'(xcnt), 64'd100);
    chk("t6_tx", 64'(tx_count), 64'd100);

    set_mode(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
